// File: rtl/lut_2b_div_pkg.sv
// Shared types and constants for the radix-4 LUT divider.
// Optional early-exit build is selected with LUT_2B_DIV_EARLY_EXIT_EN.
package lut_2b_div_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_ITER  = DEF_N;
  localparam int DEF_CNT_W = $clog2(DEF_ITER);
  localparam int MAX_N     = 64;

  // Divide-by-zero quotient; sliced down to 2*N bits by the user.
  localparam logic [2*MAX_N-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/lut_2b_div_digit_sel.sv
// Radix-4 digit selection: picks the largest divisor multiple not above t
// and returns the digit plus the reduced partial remainder.
module lut_2b_div_digit_sel
  import lut_2b_div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N+1:0] t,
  input  logic [N+1:0] m1,
  input  logic [N+1:0] m2,
  input  logic [N+1:0] m3,
  output logic [1:0]   q,
  output logic [N+1:0] r_new
);

  logic ge1;
  logic ge2;
  logic ge3;

  assign ge1 = (t >= m1);
  assign ge2 = (t >= m2);
  assign ge3 = (t >= m3);

  always_comb begin
    q     = 2'd0;
    r_new = t;
    if (ge3) begin
      q     = 2'd3;
      r_new = t - m3;
    end else if (ge2) begin
      q     = 2'd2;
      r_new = t - m2;
    end else if (ge1) begin
      q     = 2'd1;
      r_new = t - m1;
    end
  end

endmodule

// File: rtl/lut_2b_divider.sv
// Radix-4 restoring divider: 2*N-bit dividend / N-bit divisor, 2 quotient bits per cycle.
// Define LUT_2B_DIV_EARLY_EXIT_EN to skip leading all-zero dividend pairs.
module lut_2b_divider
  import lut_2b_div_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int ITER = N
) (
  input  logic           clk_2b,
  input  logic           reset_2b,
  input  logic           start_2b,
  input  logic [2*N-1:0] dividend_2b,
  input  logic [N-1:0]   divisor_2b,
  output logic           ready_2b,
  output logic           done_2b,
  output logic [2*N-1:0] quotient_2b,
  output logic [N-1:0]   remainder_2b,
  output logic           div_zero_2b
);

  localparam int CNT_W = $clog2(ITER);
  localparam int RW    = N + 2;

  state_e           state_q, state_d;
  logic [2*N-1:0]   dividend_q, dividend_d;
  logic [N-1:0]     divisor_q, divisor_d;
  logic [RW-1:0]    m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic [RW-1:0]    r_q, r_d;
  logic [2*N-1:0]   quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [RW-1:0]    t;
  logic [RW-1:0]    r_next;
  logic [1:0]       q_digit;

  // The remaining dividend is kept left-aligned so its next pair is always the top two bits.
  assign t = (r_q << 2) | RW'(dividend_q[2*N-1 -: 2]);

  lut_2b_div_digit_sel #(.N(N)) u_digit_sel (
    .t     (t),
    .m1    (m1_q),
    .m2    (m2_q),
    .m3    (m3_q),
    .q     (q_digit),
    .r_new (r_next)
  );

`ifdef LUT_2B_DIV_EARLY_EXIT_EN
  logic [CNT_W:0] lz;
  logic           lz_hit;

  always_comb begin
    lz     = '0;
    lz_hit = 1'b0;
    for (int i = ITER - 1; i >= 0; i--) begin
      if (!lz_hit && dividend_q[2*i +: 2] == 2'b00) begin
        lz = lz + 1'b1;
      end else begin
        lz_hit = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    m3_d        = m3_q;
    r_d         = r_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start_2b) begin
          dividend_d = dividend_2b;
          divisor_d  = divisor_2b;
          div_zero_d = 1'b0;
          if (divisor_2b == '0) begin
            div_zero_d  = 1'b1;
            quotient_d  = DIV0_QUOT[2*N-1:0];
            remainder_d = dividend_2b[N-1:0];
            state_d     = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        m1_d    = RW'(divisor_q);
        m2_d    = RW'(divisor_q) << 1;
        m3_d    = RW'(divisor_q) + (RW'(divisor_q) << 1);
        r_d     = '0;
        quot_d  = '0;
        cnt_d   = CNT_W'(ITER - 1);
        state_d = lut_2b_div_pkg::ITER;
`ifdef LUT_2B_DIV_EARLY_EXIT_EN
        if (dividend_q == '0) begin
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = DONE;
        end else begin
          dividend_d = dividend_q << (2 * lz);
          cnt_d      = CNT_W'(ITER - 1 - int'(lz));
        end
`endif
      end
      lut_2b_div_pkg::ITER: begin
        r_d        = r_next;
        quot_d     = {quot_q[2*N-3:0], q_digit};
        dividend_d = dividend_q << 2;
        // Results are published on entry to DONE so they are valid while done_2b is high.
        if (cnt_q == '0) begin
          quotient_d  = {quot_q[2*N-3:0], q_digit};
          remainder_d = r_next[N-1:0];
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2b) begin
    if (reset_2b) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      m3_q        <= '0;
      r_q         <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      m3_q        <= m3_d;
      r_q         <= r_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign ready_2b     = (state_q == IDLE);
  assign done_2b      = (state_q == DONE);
  assign quotient_2b  = quotient_q;
  assign remainder_2b = remainder_q;
  assign div_zero_2b  = div_zero_q;

endmodule

// File: tb/tb_lut_2b_divider.sv
// Self-checking bench for lut_2b_divider: vector table plus scoreboard queue,
// with hand-written sequences for busy-start, mid-operation reset and divide by zero.
module tb_lut_2b_divider;

  localparam int N    = 32;
  localparam int ITER = N;

  logic          clk_2b = 1'b0;
  logic          reset_2b;
  logic          start_2b;
  logic [63:0]   dividend_2b;
  logic [31:0]   divisor_2b;
  logic          ready_2b;
  logic          done_2b;
  logic [63:0]   quotient_2b;
  logic [31:0]   remainder_2b;
  logic          div_zero_2b;

  always #5 clk_2b = ~clk_2b;

  lut_2b_divider #(.N(N)) dut (
    .clk_2b       (clk_2b),
    .reset_2b     (reset_2b),
    .start_2b     (start_2b),
    .dividend_2b  (dividend_2b),
    .divisor_2b   (divisor_2b),
    .ready_2b     (ready_2b),
    .done_2b      (done_2b),
    .quotient_2b  (quotient_2b),
    .remainder_2b (remainder_2b),
    .div_zero_2b  (div_zero_2b)
  );

  typedef struct {
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [63:0] quot;
    logic [31:0] rem;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [63:0] quot;
    logic [31:0] rem;
    logic        dz;
    int          doneCycle;
    int          id;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   opId   = 0;

  initial forever begin
    @(posedge clk_2b);
    cycle++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Edges from the start-sampling edge until done_2b is visible.
  function automatic int expLatency(input logic [63:0] dvd, input logic [31:0] dvs);
    int lat;
    lat = 1 + ITER + 1;
    if (dvs == 32'd0) begin
      lat = 1;
    end
`ifdef LUT_2B_DIV_EARLY_EXIT_EN
    else begin
      int z;
      bit hit;
      z   = 0;
      hit = 1'b0;
      for (int i = ITER - 1; i >= 0; i--) begin
        if (!hit && dvd[2*i +: 2] == 2'b00) z++;
        else hit = 1'b1;
      end
      lat = 2 + (ITER - z);
    end
`endif
    return lat;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding operation.
  initial forever begin
    exp_t e;
    @(posedge clk_2b);
    #1;
    if (done_2b === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 (cycle %0d)", cycle);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("quot_op%0d", e.id), quotient_2b, e.quot);
        checkOutput($sformatf("rem_op%0d", e.id), {32'd0, remainder_2b}, {32'd0, e.rem});
        checkOutput($sformatf("dz_op%0d", e.id), {63'd0, div_zero_2b}, {63'd0, e.dz});
        checkOutput($sformatf("lat_op%0d", e.id), 64'(cycle), 64'(e.doneCycle));
      end
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    while (ready_2b !== 1'b1 && n < 500) begin
      @(negedge clk_2b);
      n++;
    end
    if (ready_2b !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout actual=%b required=1", ready_2b);
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk_2b);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout actual=%0d required=0 outstanding", sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs,
                               input logic [63:0] q, input logic [31:0] r,
                               input logic dz, input bit track);
    exp_t e;
    @(negedge clk_2b);
    waitReady();
    dividend_2b = dvd;
    divisor_2b  = dvs;
    start_2b    = 1'b1;
    if (track) begin
      e.quot      = q;
      e.rem       = r;
      e.dz        = dz;
      e.doneCycle = cycle + expLatency(dvd, dvs);
      e.id        = opId;
      opId++;
      sb.push_back(e);
    end
    @(negedge clk_2b);
    start_2b    = 1'b0;
    dividend_2b = {$urandom, $urandom};
    divisor_2b  = $urandom;
  endtask

  initial begin
    logic [63:0] rd;
    logic [31:0] rs;

    reset_2b    = 1'b1;
    start_2b    = 1'b0;
    dividend_2b = '0;
    divisor_2b  = '0;

    vecs[0]  = '{dividend: 64'd2556441, divisor: 32'd3, quot: 64'd852147, rem: 32'd0, dz: 1'b0};
    vecs[1]  = '{dividend: 64'd2556442, divisor: 32'd3, quot: 64'd852147, rem: 32'd1, dz: 1'b0};
    vecs[2]  = '{dividend: 64'hFFFF_FFFF_FFFF_FFFF, divisor: 32'hFFFF_FFFF,
                 quot: 64'h0000_0001_0000_0001, rem: 32'd0, dz: 1'b0};
    vecs[3]  = '{dividend: 64'h1234_5678_9ABC_DEF0, divisor: 32'd0,
                 quot: 64'hFFFF_FFFF_FFFF_FFFF, rem: 32'h9ABC_DEF0, dz: 1'b1};
    vecs[4]  = '{dividend: 64'd1000, divisor: 32'd1000, quot: 64'd1, rem: 32'd0, dz: 1'b0};
    vecs[5]  = '{dividend: 64'd83810205, divisor: 32'd6789, quot: 64'd12345, rem: 32'd0, dz: 1'b0};
    vecs[6]  = '{dividend: 64'd83810305, divisor: 32'd6789, quot: 64'd12345, rem: 32'd100, dz: 1'b0};
    vecs[7]  = '{dividend: 64'd5, divisor: 32'd9, quot: 64'd0, rem: 32'd5, dz: 1'b0};
    vecs[8]  = '{dividend: 64'hFFFF_FFFF_FFFF_FFFF, divisor: 32'd1,
                 quot: 64'hFFFF_FFFF_FFFF_FFFF, rem: 32'd0, dz: 1'b0};
    vecs[9]  = '{dividend: 64'd7, divisor: 32'd2, quot: 64'd3, rem: 32'd1, dz: 1'b0};
    vecs[10] = '{dividend: 64'd0, divisor: 32'd5, quot: 64'd0, rem: 32'd0, dz: 1'b0};
    vecs[11] = '{dividend: 64'h8000_0000_0000_0000, divisor: 32'h8000_0000,
                 quot: 64'h0000_0001_0000_0000, rem: 32'd0, dz: 1'b0};

    repeat (2) @(posedge clk_2b);
    #1;
    checkOutput("rst_ready", {63'd0, ready_2b}, 64'd1);
    checkOutput("rst_done", {63'd0, done_2b}, 64'd0);
    checkOutput("rst_quot", quotient_2b, 64'd0);
    checkOutput("rst_rem", {32'd0, remainder_2b}, 64'd0);
    checkOutput("rst_dz", {63'd0, div_zero_2b}, 64'd0);
    @(negedge clk_2b);
    reset_2b = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].quot, vecs[i].rem, vecs[i].dz, 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      rd = {$urandom, $urandom};
      rs = (i[0]) ? (32'($urandom_range(1, 255))) : ($urandom | 32'h1);
      applyStimulus(rd, rs, rd / {32'd0, rs}, 32'(rd % {32'd0, rs}), 1'b0, 1'b1);
    end
    waitDrain();

    $display("[TB] start while busy must be ignored");
    applyStimulus(64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 1'b1);
    repeat (2) @(negedge clk_2b);
    dividend_2b = 64'd5;
    divisor_2b  = 32'd1;
    start_2b    = 1'b1;
    @(negedge clk_2b);
    start_2b = 1'b0;
    checkOutput("busy_ready", {63'd0, ready_2b}, 64'd0);
    waitDrain();
    repeat (40) @(negedge clk_2b);

    $display("[TB] reset during an operation");
    applyStimulus(64'hDEAD_BEEF_0000_1234, 32'h1357, 64'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_2b);
    checkOutput("mid_ready", {63'd0, ready_2b}, 64'd0);
    reset_2b = 1'b1;
    @(posedge clk_2b);
    #1;
    checkOutput("midrst_ready", {63'd0, ready_2b}, 64'd1);
    checkOutput("midrst_done", {63'd0, done_2b}, 64'd0);
    checkOutput("midrst_quot", quotient_2b, 64'd0);
    checkOutput("midrst_rem", {32'd0, remainder_2b}, 64'd0);
    checkOutput("midrst_dz", {63'd0, div_zero_2b}, 64'd0);
    @(negedge clk_2b);
    reset_2b = 1'b0;
    applyStimulus(64'd9, 32'd4, 64'd2, 32'd1, 1'b0, 1'b1);
    waitDrain();
    repeat (40) @(negedge clk_2b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
